// File: rtl/alu_sequencer_if.sv
// Request/response and ALU-side signal bundle for the multi-cycle ALU sequencer.
// The slave modport is the sequencer; the master modport is the requester plus ALU.
interface alu_sequencer_if;
    logic       start;
    logic       op;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] rem;
    logic       err;
    logic [1:0] alu_ctl;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic       alu_zero;

    modport master (
        output start, op, opa, opb, alu_out, alu_zero,
        input  busy, done, result, rem, err, alu_ctl, alu_a, alu_b
    );

    modport slave (
        input  start, op, opa, opb, alu_out, alu_zero,
        output busy, done, result, rem, err, alu_ctl, alu_a, alu_b
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencing master for the 8-bit ALU: shift-add multiply and repeated-subtract
// divide, issuing one ALU operation per clock.
module alu_sequencer (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MUL, DCMP, DSUB, DONE} state_t;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_SLT = 2'd2;

    state_t     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] mcand_q, mcand_d;
    logic [7:0] mplier_q, mplier_d;
    logic [7:0] divisor_q, divisor_d;
    logic [7:0] r_q, r_d;
    logic [7:0] q_q, q_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic [7:0] rem_q, rem_d;
    logic       err_q, err_d;
    logic [1:0] alu_ctl;
    logic [7:0] alu_a;
    logic [7:0] alu_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            divisor_q <= '0;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            divisor_q <= divisor_d;
            r_q       <= r_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        divisor_d = divisor_q;
        r_d       = r_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        rem_d     = rem_q;
        err_d     = err_q;
        alu_ctl   = ALU_ADD;
        alu_a     = '0;
        alu_b     = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d = 1'b0;
                    if (!bus.op) begin
                        acc_d    = '0;
                        mcand_d  = bus.opa;
                        mplier_d = bus.opb;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else if (bus.opb == 8'd0 || bus.opa[7] || bus.opb[7]) begin
                        // Zero or negative operands cannot be handled by repeated subtraction.
                        result_d = 8'hFF;
                        rem_d    = bus.opa;
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end else begin
                        r_d       = bus.opa;
                        q_d       = '0;
                        divisor_d = bus.opb;
                        state_d   = DCMP;
                    end
                end
            end
            MUL: begin
                alu_ctl  = ALU_ADD;
                alu_a    = acc_q;
                alu_b    = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = bus.alu_out;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    result_d = mplier_q[0] ? bus.alu_out : acc_q;
                    rem_d    = '0;
                    state_d  = DONE;
                end
            end
            DCMP: begin
                alu_ctl = ALU_SLT;
                alu_a   = r_q;
                alu_b   = divisor_q;
                if (bus.alu_out[0]) begin
                    result_d = q_q;
                    rem_d    = r_q;
                    state_d  = DONE;
                end else begin
                    state_d = DSUB;
                end
            end
            DSUB: begin
                alu_ctl = ALU_SUB;
                alu_a   = r_q;
                alu_b   = divisor_q;
                r_d     = bus.alu_out;
                q_d     = q_q + 8'd1;
                // A zero difference means an exact division; skip the final compare.
                if (bus.alu_zero) begin
                    result_d = q_q + 8'd1;
                    rem_d    = '0;
                    state_d  = DONE;
                end else begin
                    state_d = DCMP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy    = (state_q == MUL) || (state_q == DCMP) || (state_q == DSUB);
    assign bus.done    = (state_q == DONE);
    assign bus.result  = result_q;
    assign bus.rem     = rem_q;
    assign bus.err     = err_q;
    assign bus.alu_ctl = alu_ctl;
    assign bus.alu_a   = alu_a;
    assign bus.alu_b   = alu_b;
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle initiator that drives the 8-bit ALU's control/operand interface (ALUctl, A, B) and consumes its result (ALUOut, Zero). It implements 8-bit truncated multiply (shift-add) and non-negative 7-bit divide (repeated subtract), issuing one ALU operation per clock. It sits beside the datapath ALU as the sequencing master for instructions the ALU cannot complete in one combinational pass.

## Interface
- No parameters; all widths fixed at 8 bits to match the ALU.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide.
- opa  in  8  multiplicand / dividend.
- opb  in  8  multiplier / divisor.
- busy  out  1  high in MUL, DCMP, DSUB.
- done  out  1  one-cycle pulse in DONE.
- result  out  8  product low byte or quotient; holds until next accepted start.
- rem  out  8  remainder (divide); 0 after multiply.
- err  out  1  divide error flag; valid with done, holds with result.
- alu_ctl  out  2  to ALU: 0 add, 1 sub, 2 signed set-less-than, 3 B<<4 (never issued).
- alu_a, alu_b  out  8  ALU operands.
- alu_out  in  8  ALU result, combinational, same cycle.
- alu_zero  in  1  ALU zero flag (alu_out == 0).

## Operation
- States: IDLE, MUL, DCMP, DSUB, DONE. Reset -> IDLE; busy=0, done=0, result=0, rem=0, err=0, internal acc/mcand/mplier/R/Q/cnt=0.
- ALU outputs in IDLE and DONE: alu_ctl=0, alu_a=0, alu_b=0.
- IDLE & start: latch operands, clear err.
  - op=0: acc=0, mcand=opa, mplier=opb, cnt=0 -> MUL.
  - op=1 and (opb==0 or opa[7] or opb[7]): result=0xFF, rem=opa, err=1 -> DONE.
  - op=1 otherwise: R=opa, Q=0 -> DCMP.
- MUL (one bit per cycle, cnt 0..7): alu_ctl=0, alu_a=acc, alu_b=mcand; if mplier[0], acc<=alu_out. mcand<<=1, mplier>>=1, cnt++ (internal shifts, not via ALU). After cnt=7 processed: result<=final acc, rem<=0 -> DONE. Product is low 8 bits, mod 256 (valid for two's-complement too).
- DCMP: alu_ctl=2, alu_a=R, alu_b=opb. alu_out[0]=1 (R<divisor) -> result<=Q, rem<=R, DONE; else -> DSUB.
- DSUB: alu_ctl=1, alu_a=R, alu_b=opb; R<=alu_out, Q<=Q+1. If alu_zero: result<=Q+1, rem<=0, DONE (early exit); else -> DCMP.
- DONE: done=1 for exactly one cycle -> IDLE unconditionally.
- start outside IDLE (including DONE) ignored; operand changes after acceptance ignored.

## Timing
- Accepting edge = E0; busy rises after E0 (except error path).
- Multiply: bits processed on E1..E8; done high in cycle after E8 (9 cycles after acceptance), busy low in that cycle.
- Divide, non-exact: 2Q+1 edges after E0 to enter DONE. Exact (remainder 0): 2Q edges.
- Error divide: done high in cycle after E0; busy never asserts.
- Back-to-back: earliest next accept is the IDLE cycle after DONE (issue interval = latency + 1).
- Reset asserted mid-operation: immediate return to IDLE, all outputs 0, no done pulse; result/rem/err from prior operation lost.

## Test plan
- Reset mid-MUL at E4 -> busy=0, done=0, result=0 immediately; next start op=0 13x11 runs clean.
- start op=0, opa=13, opb=11 -> done in cycle after E8, result=0x8F, rem=0, err=0; alu_ctl=0 every busy cycle.
- start op=0, opa=0xFF, opb=0xFF -> result=0x01; opb=0 -> result=0x00, still 9-cycle latency.
- start op=1, opa=100, opb=7 -> done after E29, result=14, rem=2; alu_ctl alternates 2,1 and ends on 2.
- start op=1, opa=21, opb=7 -> early exit, done after E6, result=3, rem=0; opa=5, opb=9 -> done after E1, result=0, rem=5.
- start op=1 with opb=0, and separately opa=0x80 -> done after E0, err=1, result=0xFF, rem=opa; start pulsed during busy and DONE -> ignored, result unchanged.
